// File: rtl/sdrd_cluster_sequencer.sv
// FAT32 cluster-chain walker: issues data and FAT sector reads to the SPI reader.
// Optional ABORT input when SDRD_SEQ_ABORT_EN is defined.
module sdrd_cluster_sequencer #(
    parameter int MAX_CLUSTERS = 4096,
    parameter int ADR_W        = 32
) (
    input  logic             CLK,
    input  logic             RST,
`ifdef SDRD_SEQ_ABORT_EN
    input  logic             ABORT,
`endif
    input  logic             START,
    input  logic [ADR_W-1:0] START_CLUSTER,
    input  logic [2:0]       SPC_LOG2,
    input  logic [ADR_W-1:0] FAT_BEGIN_LBA,
    input  logic [ADR_W-1:0] CLUS_BEGIN_LBA,
    output logic             REQ_VALID,
    input  logic             REQ_READY,
    output logic [ADR_W-1:0] REQ_ADR,
    output logic [1:0]       REQ_TYPE,
    output logic [6:0]       FAT_OFS,
    input  logic             SEC_DONE,
    input  logic             FAT_VALID,
    input  logic [ADR_W-1:0] FAT_ENTRY,
    output logic [ADR_W-1:0] CUR_CLUSTER,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);

    localparam int CNT_W = $clog2(MAX_CLUSTERS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CLUSTERS);
    localparam logic [ADR_W-1:0] BAD_CLUS = ADR_W'(32'h0FFF_FFF7);
    localparam logic [ADR_W-1:0] EOC_MIN  = ADR_W'(32'h0FFF_FFF8);
    localparam logic [ADR_W-1:0] ENT_MASK = ADR_W'(32'h0FFF_FFFF);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DREQ,
        DWAIT,
        FREQ,
        FWAIT,
        FIN,
        FAIL
    } state_t;

    state_t state;
    state_t state_nx;

    logic [ADR_W-1:0] cur;
    logic [2:0]       spc;
    logic [ADR_W-1:0] fat_lba;
    logic [ADR_W-1:0] clus_lba;
    logic [6:0]       sec_idx;
    logic [CNT_W-1:0] clus_cnt;
    logic             err;

    logic             abort;
    logic             ld_start;
    logic             sec_inc;
    logic             sec_clr;
    logic             clus_ld;
    logic             err_set;
    logic [7:0]       span;
    logic [6:0]       sec_last;
    logic [ADR_W-1:0] entry_m;
    logic [ADR_W-1:0] data_adr;
    logic [ADR_W-1:0] fat_adr;

`ifdef SDRD_SEQ_ABORT_EN
    assign abort = ABORT;
`else
    assign abort = 1'b0;
`endif

    assign span     = 8'd1 << spc;
    assign sec_last = 7'(span - 8'd1);
    assign entry_m  = FAT_ENTRY & ENT_MASK;
    assign data_adr = clus_lba + ((cur - ADR_W'(2)) << spc) + ADR_W'(sec_idx);
    assign fat_adr  = fat_lba + (cur >> 7);

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and datapath strobes
    always_comb begin
        state_nx = state;
        ld_start = 1'b0;
        sec_inc  = 1'b0;
        sec_clr  = 1'b0;
        clus_ld  = 1'b0;
        err_set  = 1'b0;
        unique case (state)
            IDLE: begin
                if (START) begin
                    ld_start = 1'b1;
                    state_nx = CHECK;
                end
            end
            CHECK: begin
                if (cur < ADR_W'(2) || cur == BAD_CLUS || clus_cnt == CNT_MAX) begin
                    state_nx = FAIL;
                end else begin
                    state_nx = DREQ;
                end
            end
            DREQ: begin
                if (REQ_READY) begin
                    state_nx = DWAIT;
                end
            end
            DWAIT: begin
                if (SEC_DONE) begin
                    if (sec_idx == sec_last) begin
                        sec_clr  = 1'b1;
                        state_nx = FREQ;
                    end else begin
                        sec_inc  = 1'b1;
                        state_nx = DREQ;
                    end
                end
            end
            FREQ: begin
                if (REQ_READY) begin
                    state_nx = FWAIT;
                end
            end
            FWAIT: begin
                if (FAT_VALID) begin
                    if (entry_m >= EOC_MIN) begin
                        state_nx = FIN;
                    end else begin
                        clus_ld  = 1'b1;
                        state_nx = CHECK;
                    end
                end
            end
            FIN: begin
                state_nx = IDLE;
            end
            FAIL: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        // An abort drops whatever the chain was doing, including a request
        // handed over in this same cycle; the error flag is left untouched.
        if (abort && state != IDLE) begin
            state_nx = IDLE;
            sec_inc  = 1'b0;
            sec_clr  = 1'b0;
            clus_ld  = 1'b0;
        end
        err_set = (state_nx == FAIL);
    end

    // Config latch, cluster/sector counters and sticky error
    always_ff @(posedge CLK) begin
        if (RST) begin
            cur      <= '0;
            spc      <= '0;
            fat_lba  <= '0;
            clus_lba <= '0;
            sec_idx  <= '0;
            clus_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (ld_start) begin
                cur      <= START_CLUSTER;
                spc      <= SPC_LOG2;
                fat_lba  <= FAT_BEGIN_LBA;
                clus_lba <= CLUS_BEGIN_LBA;
                sec_idx  <= '0;
                clus_cnt <= '0;
                err      <= 1'b0;
            end
            if (sec_inc) begin
                sec_idx <= sec_idx + 7'd1;
            end
            if (sec_clr) begin
                sec_idx <= '0;
            end
            if (clus_ld) begin
                cur      <= entry_m;
                clus_cnt <= clus_cnt + CNT_W'(1);
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    // Request outputs are decoded from registered state so they hold during a stall
    always_comb begin
        REQ_ADR  = '0;
        REQ_TYPE = 2'b00;
        FAT_OFS  = 7'd0;
        if (state == DREQ) begin
            REQ_ADR = data_adr;
        end else if (state == FREQ) begin
            REQ_ADR  = fat_adr;
            REQ_TYPE = 2'b01;
            FAT_OFS  = cur[6:0];
        end
    end

    assign REQ_VALID   = (state == DREQ) || (state == FREQ);
    assign BUSY        = (state != IDLE);
    assign DONE        = (state == FIN);
    assign ERR         = err;
    assign CUR_CLUSTER = cur;

endmodule

// File: tb/tb_sdrd_cluster_sequencer.sv
// Directed bench for sdrd_cluster_sequencer: per-cycle vector table plus
// hand sequences for stall, loop guard, reset and (optionally) abort.
module tb_sdrd_cluster_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] start_cluster = '0;
    logic [2:0]  spc_log2 = '0;
    logic [31:0] fat_begin_lba = 32'h20;
    logic [31:0] clus_begin_lba = 32'h2000;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_adr;
    logic [1:0]  req_type;
    logic [6:0]  fat_ofs;
    logic        sec_done = 1'b0;
    logic        fat_valid = 1'b0;
    logic [31:0] fat_entry = '0;
    logic [31:0] cur_cluster;
    logic        busy;
    logic        done;
    logic        err;
`ifdef SDRD_SEQ_ABORT_EN
    logic        abort = 1'b0;
`endif

    int n_vec = 0;
    int n_bad = 0;

    sdrd_cluster_sequencer #(
        .MAX_CLUSTERS(4),
        .ADR_W(32)
    ) dut (
        .CLK(clk),
        .RST(rst),
`ifdef SDRD_SEQ_ABORT_EN
        .ABORT(abort),
`endif
        .START(start),
        .START_CLUSTER(start_cluster),
        .SPC_LOG2(spc_log2),
        .FAT_BEGIN_LBA(fat_begin_lba),
        .CLUS_BEGIN_LBA(clus_begin_lba),
        .REQ_VALID(req_valid),
        .REQ_READY(req_ready),
        .REQ_ADR(req_adr),
        .REQ_TYPE(req_type),
        .FAT_OFS(fat_ofs),
        .SEC_DONE(sec_done),
        .FAT_VALID(fat_valid),
        .FAT_ENTRY(fat_entry),
        .CUR_CLUSTER(cur_cluster),
        .BUSY(busy),
        .DONE(done),
        .ERR(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [31:0] sc;
        logic [2:0]  sp;
        logic        rd;
        logic        sd;
        logic        fv;
        logic [31:0] en;
        logic        e_vld;
        logic [31:0] e_adr;
        logic [1:0]  e_typ;
        logic [6:0]  e_ofs;
        logic [31:0] e_cur;
        logic        e_busy;
        logic        e_done;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(
        input logic st, input logic [31:0] sc, input logic [2:0] sp,
        input logic rd, input logic sd, input logic fv, input logic [31:0] en,
        input logic ev, input logic [31:0] ea, input logic [1:0] et,
        input logic [6:0] eo, input logic [31:0] ec,
        input logic eb, input logic ed, input logic ee);
        vec_t r;
        r.st = st; r.sc = sc; r.sp = sp;
        r.rd = rd; r.sd = sd; r.fv = fv; r.en = en;
        r.e_vld = ev; r.e_adr = ea; r.e_typ = et; r.e_ofs = eo;
        r.e_cur = ec; r.e_busy = eb; r.e_done = ed; r.e_err = ee;
        return r;
    endfunction

    task automatic chk(input string nm, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait reader: answers each handshake one cycle later.
    // FAT reads 1..links return cluster 9, later ones return end-of-chain.
    task automatic run_chain(input int links, output int freads,
                             output int dones, output bit tmo);
        logic pd;
        logic pf;
        pd = 1'b0;
        pf = 1'b0;
        freads = 0;
        dones = 0;
        tmo = 1'b1;
        start = 1'b1;
        start_cluster = 32'd9;
        spc_log2 = 3'd0;
        req_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (!busy) begin
                tmo = 1'b0;
                break;
            end
            sec_done = pd;
            fat_valid = pf;
            fat_entry = (freads <= links) ? 32'd9 : 32'h0FFF_FFFF;
            @(negedge clk);
            pd = req_valid && (req_type == 2'b00);
            pf = req_valid && (req_type == 2'b01);
            if (pf) freads++;
            if (done) dones++;
            tick();
        end
        sec_done = 1'b0;
        fat_valid = 1'b0;
    endtask

    initial begin
        int fr;
        int dn;
        bit to;
        int xfers;

        // Test 1: SPC_LOG2=2, cluster 5, one-cluster chain
        vecs.push_back(v(1, 5, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 1, 32'h200C, 0, 0, 5, 1, 0, 0));
        vecs.push_back(v(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 1, 32'h200D, 0, 0, 5, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 1, 32'h200E, 0, 0, 5, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 1, 32'h200F, 0, 0, 5, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 1, 32'h20, 1, 5, 5, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 1, 32'h0FFFFFFF, 0, 0, 0, 0, 5, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 5, 1, 1, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0));
        // Test 2: chain 3 -> 0x85 -> EOC, stray responses ignored
        vecs.push_back(v(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 1, 32'h2001, 0, 0, 3, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 1, 32'h20, 1, 3, 3, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 1, 1, 32'h85, 0, 0, 0, 0, 3, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h85, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 1, 32'h2083, 0, 0, 32'h85, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 1, 32'h0FFFFFFF, 0, 0, 0, 0, 32'h85, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 32'h85, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 1, 32'h21, 1, 5, 32'h85, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 1, 32'h0FFFFFF8, 0, 0, 0, 0, 32'h85, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h85, 1, 1, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h85, 0, 0, 0));
        // Test 4: masked entry -> cluster 1 -> error; bad-cluster and zero start
        vecs.push_back(v(1, 32'h10, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h85, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h10, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 1, 32'h200E, 0, 0, 32'h10, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 32'h10, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 1, 32'h20, 1, 7'h10, 32'h10, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 1, 32'hF0000001, 0, 0, 0, 0, 32'h10, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(v(1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 1, 32'h2000, 0, 0, 2, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 1, 32'h20, 1, 2, 2, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 1, 32'h0FFFFFF7, 0, 0, 0, 0, 2, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0FFFFFF7, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0FFFFFF7, 1, 0, 1));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0FFFFFF7, 0, 0, 1));
        vecs.push_back(v(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0FFFFFF7, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_vld", -1, req_valid, 0);
        chk("rst_adr", -1, req_adr, 0);
        chk("rst_typ", -1, req_type, 0);
        chk("rst_ofs", -1, fat_ofs, 0);
        chk("rst_cur", -1, cur_cluster, 0);
        chk("rst_busy", -1, busy, 0);
        chk("rst_done", -1, done, 0);
        chk("rst_err", -1, err, 0);
        tick();

        foreach (vecs[i]) begin
            start = vecs[i].st;
            start_cluster = vecs[i].sc;
            spc_log2 = vecs[i].sp;
            req_ready = vecs[i].rd;
            sec_done = vecs[i].sd;
            fat_valid = vecs[i].fv;
            fat_entry = vecs[i].en;
            @(negedge clk);
            chk("vld", i, req_valid, vecs[i].e_vld);
            if (vecs[i].e_vld) begin
                chk("adr", i, req_adr, vecs[i].e_adr);
                chk("typ", i, req_type, vecs[i].e_typ);
                if (vecs[i].e_typ == 2'b01) chk("ofs", i, fat_ofs, vecs[i].e_ofs);
            end
            chk("cur", i, cur_cluster, vecs[i].e_cur);
            chk("busy", i, busy, vecs[i].e_busy);
            chk("done", i, done, vecs[i].e_done);
            chk("err", i, err, vecs[i].e_err);
            tick();
        end
        start = 1'b0;
        sec_done = 1'b0;
        fat_valid = 1'b0;

        // Test 5: four-cluster chain completes; self-loop hits the guard
        run_chain(3, fr, dn, to);
        chk("ch4_tmo", 0, to, 0);
        chk("ch4_freads", 0, fr, 4);
        chk("ch4_done", 0, dn, 1);
        chk("ch4_err", 0, err, 0);
        run_chain(1000, fr, dn, to);
        chk("loop_tmo", 0, to, 0);
        chk("loop_freads", 0, fr, 4);
        chk("loop_done", 0, dn, 0);
        chk("loop_err", 0, err, 1);

        // Test 3: ten stalled cycles in DREQ, then exactly one transfer
        start = 1'b1;
        start_cluster = 32'd5;
        spc_log2 = 3'd0;
        req_ready = 1'b0;
        tick();
        start = 1'b0;
        tick();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("stall_vld", k, req_valid, 1);
            chk("stall_adr", k, req_adr, 32'h2003);
            tick();
        end
        req_ready = 1'b1;
        xfers = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (req_valid && req_ready) xfers++;
            tick();
        end
        chk("stall_xfers", 0, xfers, 1);
        @(negedge clk);
        chk("stall_busy", 0, busy, 1);

        // Test 6: reset while waiting for SEC_DONE
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_ready = 1'b0;
        @(negedge clk);
        chk("rst2_vld", 0, req_valid, 0);
        chk("rst2_cur", 0, cur_cluster, 0);
        chk("rst2_busy", 0, busy, 0);
        chk("rst2_done", 0, done, 0);
        chk("rst2_err", 0, err, 0);
        tick();

`ifdef SDRD_SEQ_ABORT_EN
        // Abort while waiting for the FAT entry
        start = 1'b1;
        start_cluster = 32'd5;
        req_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        sec_done = 1'b1;
        tick();
        sec_done = 1'b0;
        tick();
        @(negedge clk);
        chk("abt_pre_busy", 0, busy, 1);
        chk("abt_pre_vld", 0, req_valid, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("abt_busy", 0, busy, 0);
        chk("abt_done", 0, done, 0);
        chk("abt_err", 0, err, 0);
        tick();
        @(negedge clk);
        chk("abt_idle", 0, busy, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
